// File: rtl/apu_mix_scheduler.sv
// rtl/apu_mix_scheduler.sv - polls APU voice channels, gains and sums them into one codec sample
module apu_mix_scheduler #(
  parameter int NUM_CH  = 5,
  parameter int CH_W    = 8,
  parameter int GAIN_W  = 6,
  parameter int OUT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_req,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic [NUM_CH*GAIN_W-1:0] ch_gain,
  output logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_ack,
  input  logic [NUM_CH*CH_W-1:0]   ch_data,
  output logic [OUT_W-1:0]         audio_output,
  output logic                     busy,
  output logic                     underrun,
  output logic                     timeout_err,
  input  logic                     status_clr
);

  localparam int IDX_W = $clog2(NUM_CH + 1);
  localparam int ACC_W = CH_W + GAIN_W + IDX_W;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, REQ, DONE} state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic [ACC_W-1:0]    r_acc;
  logic [NUM_CH-1:0]   r_ch_req;
  logic [OUT_W-1:0]    r_audio;
  logic                r_busy;
  logic                r_underrun;
  logic                r_timeout_err;

  logic [CH_W-1:0]     w_data;
  logic [GAIN_W-1:0]   w_gain;
  logic [ACC_W-1:0]    w_prod;
  logic [OUT_W-1:0]    w_sat;

  assign w_data = ch_data[r_idx*CH_W +: CH_W];
  assign w_gain = ch_gain[r_idx*GAIN_W +: GAIN_W];
  assign w_prod = ACC_W'(w_data) * ACC_W'(w_gain);
  // Clamp to the unsigned full-scale before the offset-binary flip
  assign w_sat  = (|r_acc[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : r_acc[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_ch_req      <= '0;
      r_audio       <= '0;
      r_busy        <= 1'b0;
      r_underrun    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      if (status_clr) begin
        r_underrun    <= 1'b0;
        r_timeout_err <= 1'b0;
      end
      if (sample_req && r_state != IDLE) r_underrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (sample_req) begin
            r_acc   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (r_idx == LAST_IDX) begin
            r_state <= DONE;
          end else if (!ch_enable[r_idx]) begin
            r_idx <= r_idx + 1'b1;
          end else begin
            r_ch_req <= {{(NUM_CH-1){1'b0}}, 1'b1} << r_idx;
            r_cnt    <= '0;
            r_state  <= REQ;
          end
        end
        REQ: begin
          if (ch_ack[r_idx]) begin
            r_acc    <= r_acc + w_prod;
            r_ch_req <= '0;
            r_idx    <= r_idx + 1'b1;
            r_state  <= SCAN;
          end else if (r_cnt == CNT_MAX) begin
            r_ch_req      <= '0;
            r_timeout_err <= 1'b1;
            r_idx         <= r_idx + 1'b1;
            r_state       <= SCAN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_audio <= {~w_sat[OUT_W-1], w_sat[OUT_W-2:0]};
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ch_req       = r_ch_req;
  assign audio_output = r_audio;
  assign busy         = r_busy;
  assign underrun     = r_underrun;
  assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_apu_mix_scheduler.sv
// tb/tb_apu_mix_scheduler.sv - directed bench for apu_mix_scheduler
module tb_apu_mix_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_req;
  logic [4:0]  ch_enable;
  logic [29:0] ch_gain;
  logic [4:0]  ch_req;
  logic [4:0]  ch_ack;
  logic [39:0] ch_data;
  logic [15:0] audio_output;
  logic        busy;
  logic        underrun;
  logic        timeout_err;
  logic        status_clr;
  logic [4:0]  ack_mask;

  int n_checks = 0;
  int n_fail   = 0;

  apu_mix_scheduler dut (
    .clk(clk), .reset(reset), .sample_req(sample_req), .ch_enable(ch_enable),
    .ch_gain(ch_gain), .ch_req(ch_req), .ch_ack(ch_ack), .ch_data(ch_data),
    .audio_output(audio_output), .busy(busy), .underrun(underrun),
    .timeout_err(timeout_err), .status_clr(status_clr)
  );

  always #5 clk = ~clk;

  assign ch_ack = ch_req & ack_mask;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [7:0] d, input logic [5:0] g);
    for (int i = 0; i < 5; i++) begin
      ch_data[i*8 +: 8] = d;
      ch_gain[i*6 +: 6] = g;
    end
  endtask

  // Pulses sample_req and follows the mix until busy drops (bounded)
  task automatic do_mix(input int ch, output int lat, output logic [4:0] seen, output int req_cyc);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    lat = -1;
    seen = '0;
    req_cyc = 0;
    for (int k = 1; k <= 300; k++) begin
      seen = seen | ch_req;
      if (ch_req[ch]) req_cyc++;
      if (!busy) begin
        lat = k;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) tick();
    n_checks++; if (ch_req !== 5'h00) begin n_fail++; $display("FAIL reset_ch_req got %h exp 00", ch_req); end
    n_checks++; if (audio_output !== 16'h0000) begin n_fail++; $display("FAIL reset_audio got %h exp 0000", audio_output); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got %b exp 0", underrun); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b exp 0", timeout_err); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    logic [4:0] exp_req;
    ch_enable = 5'h1F;
    ack_mask  = 5'h1F;
    set_all(8'h80, 6'd1);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      exp_req = '0;
      for (int i = 0; i < 5; i++) if (k == 2 + 2*i) exp_req[i] = 1'b1;
      if (k <= 12) begin
        n_checks++; if (ch_req !== exp_req) begin n_fail++; $display("FAIL basic_ch_req k=%0d got %h exp %h", k, ch_req, exp_req); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy k=%0d got %b exp 1", k, busy); end
        n_checks++; if (audio_output !== 16'h0000) begin n_fail++; $display("FAIL basic_hold k=%0d got %h exp 0000", k, audio_output); end
      end else begin
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end got %b exp 0", busy); end
        n_checks++; if (audio_output !== 16'h8280) begin n_fail++; $display("FAIL basic_audio got %h exp 8280", audio_output); end
      end
      if (k < 13) tick();
    end
  endtask

  task automatic test_saturate;
    int lat, rc;
    logic [4:0] seen;
    set_all(8'hFF, 6'd63);
    do_mix(0, lat, seen, rc);
    n_checks++; if (lat !== 13) begin n_fail++; $display("FAIL sat_latency got %0d exp 13", lat); end
    n_checks++; if (audio_output !== 16'h7FFF) begin n_fail++; $display("FAIL sat_audio got %h exp 7fff", audio_output); end
    set_all(8'h00, 6'd63);
    do_mix(0, lat, seen, rc);
    n_checks++; if (audio_output !== 16'h8000) begin n_fail++; $display("FAIL zero_audio got %h exp 8000", audio_output); end
    n_checks++; if (seen !== 5'h1F) begin n_fail++; $display("FAIL zero_seen got %h exp 1f", seen); end
  endtask

  task automatic test_enable_mask;
    int lat, rc;
    logic [4:0] seen;
    set_all(8'h00, 6'd2);
    ch_data[0*8 +: 8] = 8'h10;
    ch_data[2*8 +: 8] = 8'h20;
    ch_data[1*8 +: 8] = 8'h77;
    ch_enable = 5'b00101;
    do_mix(0, lat, seen, rc);
    n_checks++; if (seen !== 5'b00101) begin n_fail++; $display("FAIL mask_seen got %b exp 00101", seen); end
    n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL mask_latency got %0d exp 10", lat); end
    n_checks++; if (audio_output !== 16'h8060) begin n_fail++; $display("FAIL mask_audio got %h exp 8060", audio_output); end
    ch_enable = 5'h1F;
  endtask

  task automatic test_timeout;
    int lat, rc;
    logic [4:0] seen;
    set_all(8'h10, 6'd1);
    ack_mask = 5'b11011;
    do_mix(2, lat, seen, rc);
    ack_mask = 5'h1F;
    n_checks++; if (rc !== 64) begin n_fail++; $display("FAIL to_req_cycles got %0d exp 64", rc); end
    n_checks++; if (lat !== 76) begin n_fail++; $display("FAIL to_latency got %0d exp 76", lat); end
    n_checks++; if (audio_output !== 16'h8040) begin n_fail++; $display("FAIL to_audio got %h exp 8040", audio_output); end
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_flag got %b exp 1", timeout_err); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL to_underrun got %b exp 0", underrun); end
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clear got %b exp 0", timeout_err); end
  endtask

  task automatic test_underrun;
    set_all(8'h80, 6'd1);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      if (k == 4) sample_req = 1'b1;
      if (k == 5) begin
        sample_req = 1'b0;
        n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_flag got %b exp 1", underrun); end
      end
      if (k == 12) begin
        n_checks++; if (audio_output !== 16'h8040) begin n_fail++; $display("FAIL ur_hold got %h exp 8040", audio_output); end
      end
      if (k < 13) tick();
    end
    n_checks++; if (audio_output !== 16'h8280) begin n_fail++; $display("FAIL ur_audio got %h exp 8280", audio_output); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ur_busy_end got %b exp 0", busy); end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (busy !== 1'b0 || ch_req !== 5'h00) begin
        n_checks++; n_fail++;
        $display("FAIL ur_no_second_mix busy=%b ch_req=%h exp 0/00", busy, ch_req);
        break;
      end
    end
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL ur_clear got %b exp 0", underrun); end
  endtask

  task automatic test_reset_mid;
    int lat, rc;
    logic [4:0] seen;
    set_all(8'h80, 6'd1);
    ack_mask = 5'b10111;
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    repeat (9) tick();
    n_checks++; if (ch_req !== 5'h08) begin n_fail++; $display("FAIL mid_in_req got %h exp 08", ch_req); end
    reset = 1'b0;
    tick();
    n_checks++; if (ch_req !== 5'h00) begin n_fail++; $display("FAIL mid_ch_req got %h exp 00", ch_req); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b exp 0", busy); end
    n_checks++; if (audio_output !== 16'h0000) begin n_fail++; $display("FAIL mid_audio got %h exp 0000", audio_output); end
    reset = 1'b1;
    ack_mask = 5'h1F;
    tick();
    do_mix(0, lat, seen, rc);
    n_checks++; if (lat !== 13) begin n_fail++; $display("FAIL mid_re_latency got %0d exp 13", lat); end
    n_checks++; if (audio_output !== 16'h8280) begin n_fail++; $display("FAIL mid_re_audio got %h exp 8280", audio_output); end
  endtask

  initial begin
    reset      = 1'b0;
    sample_req = 1'b0;
    status_clr = 1'b0;
    ch_enable  = '0;
    ch_gain    = '0;
    ch_data    = '0;
    ack_mask   = '0;
    test_reset();
    test_basic();
    test_saturate();
    test_enable_mask();
    test_timeout();
    test_underrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apu_mix_scheduler.md
Name: apu_mix_scheduler

Overview:
- Sequences the APU voice generators (pulse1, pulse2, triangle, noise, DMC) into the codec's DAC sample slot.
- On each codec sample request it polls every enabled channel in fixed index order over a req/ack handshake, scales each sample by a per-channel gain, and accumulates the results.
- It saturates the sum and presents the two's-complement word on the codec's audio_output input.
- It sits between the channel generators and audio_codec, in the audio_clk domain.

Parameters:
- NUM_CH, 5: number of requester channels; channel 0 has the highest order.
- CH_W, 8: width of an unsigned channel sample.
- GAIN_W, 6: width of an unsigned per-channel gain.
- OUT_W, 16: width of audio_output.
- TIMEOUT, 64: maximum REQ cycles to wait for ch_ack before a channel is skipped.

Ports:
- clk  in  1  audio clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low; 0 resets the block.
- sample_req  in  1  one-cycle pulse from the codec: start building the next sample.
- ch_enable  in  NUM_CH  per-channel enable, sampled in SCAN.
- ch_gain  in  NUM_CH*GAIN_W  per-channel gain; channel i occupies bits [i*GAIN_W +: GAIN_W].
- ch_req  out  NUM_CH  one-hot registered fetch request.
- ch_ack  in  NUM_CH  channel response; qualified only while the matching ch_req bit is high.
- ch_data  in  NUM_CH*CH_W  channel samples, captured on a qualified ack.
- audio_output  out  OUT_W  mixed sample to the codec, registered.
- busy  out  1  high from the cycle after an accepted sample_req until audio_output updates.
- underrun  out  1  sticky; sample_req arrived while busy.
- timeout_err  out  1  sticky; a channel failed to ack within TIMEOUT cycles.
- status_clr  in  1  clears both sticky flags.

Behaviour:
- Reset values (reset=0): state IDLE, ch_req=0, audio_output=0, busy=0, underrun=0, timeout_err=0, acc=0, idx=0. The same applies when reset is asserted mid-operation: the next cycle shows ch_req=0.
- States: IDLE, SCAN, REQ, DONE.
- IDLE:
  - sample_req=1 -> acc<=0, idx<=0, busy<=1, next state SCAN.
- SCAN:
  - idx==NUM_CH -> DONE.
  - ch_enable[idx]=0 -> idx++, stay in SCAN (1 cycle per disabled channel).
  - Otherwise ch_req[idx]<=1, wait counter<=0, next state REQ.
- REQ:
  - ch_req[idx] stays high each cycle.
  - On ch_ack[idx]=1: acc += ch_data[idx]*ch_gain[idx], ch_req<=0, idx++, next state SCAN.
  - If the wait counter reaches TIMEOUT-1 with no ack: the channel contributes 0, ch_req<=0, timeout_err<=1, idx++, next state SCAN.
  - A late ack from an abandoned channel is ignored.
- DONE:
  - audio_output <= {~sat[OUT_W-1], sat[OUT_W-2:0]}, where sat = min(acc, 2^OUT_W-1). The unsigned sum is converted from offset binary to two's complement, so acc=0 gives 0x8000.
  - busy<=0, next state IDLE.
- Accumulator width: CH_W+GAIN_W+ceil(log2(NUM_CH+1)) bits, unsigned, no intermediate overflow.
- Latency: with all channels enabled and every ack in the first REQ cycle, audio_output changes 2*NUM_CH+3 cycles after the sample_req cycle (13 for NUM_CH=5). Each extra ack-wait cycle adds 1; each disabled channel costs 1 instead of 2.
- sample_req while busy (states SCAN/REQ/DONE): the request is dropped, underrun<=1, and the current mix completes unaffected.
- ch_ack bits without a matching ch_req are ignored. Only the bit for the current idx is examined.
- status_clr=1 clears both flags. A set event in the same cycle wins, so the flag reads 1.
- audio_output holds its value between updates and never changes outside DONE.
- ch_enable and ch_gain may change at any time. Each channel's values are used as sampled in its SCAN/ack cycle.

Test Plan:
- Reset, then all 5 channels enabled, gain=1, data=0x80, immediate ack, sample_req at cycle T -> ch_req walks 0x01,0x02,0x04,0x08,0x10; audio_output=0x8280 visible at T+13; busy high T+1..T+12.
- All data=0xFF, gain=63 -> sum 80325 saturates -> audio_output=0x7FFF. All data=0 -> 0x8000.
- ch_enable=5'b00101, data 0x10 and 0x20, gain 2 -> only ch_req bits 0 and 2 ever assert; audio_output=0x8060.
- Channel 2 never acks, TIMEOUT=64 -> ch_req[2] high for exactly 64 cycles, timeout_err=1, output excludes ch2. status_clr pulse -> timeout_err=0.
- Second sample_req at T+5 -> underrun=1, first result delivered unchanged at T+13, no second mix starts.
- reset driven 0 while in REQ for ch3 -> next cycle ch_req=0, busy=0, audio_output=0. After release, a fresh sample_req completes normally.
